// File: rtl/bp_feedback_sched.sv
// bp_feedback_sched: two-requester branch-feedback scheduler.
// Resolved branches from ports A and B are queued in a small circular FIFO
// and drained one per ready cycle onto a registered BHT update strobe.
// Acceptance is limited by the free space at the start of the cycle, and a
// priority bit arbitrates when only one slot remains and both ports request.
module bp_feedback_sched #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        a_valid,
    input  logic [31:0] a_pc,
    input  logic        a_tk,
    input  logic        a_mis,
    input  logic        b_valid,
    input  logic [31:0] b_pc,
    input  logic        b_tk,
    input  logic        b_mis,
    output logic        a_ready,
    output logic        b_ready,
    output logic        fb_ena,
    output logic [31:0] fb_pc,
    output logic        fb_tk,
    output logic [31:0] cnt_br,
    output logic [31:0] cnt_mis,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t            r_prio;
    prio_t            w_prio_nxt;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_wr_b;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_free;

    logic [31:0]      r_mem_pc [DEPTH];
    logic [DEPTH-1:0] r_mem_tk;

    logic             r_fb_ena;
    logic [31:0]      r_fb_pc;
    logic             r_fb_tk;
    logic [31:0]      r_cnt_br;
    logic [31:0]      r_cnt_mis;

    logic             w_a_ready;
    logic             w_b_ready;
    logic             w_acc_a;
    logic             w_acc_b;
    logic             w_pop;
    logic [1:0]       w_n_push;
    logic [1:0]       w_n_mis;

    // Space is judged on the occupancy at cycle start; a pop in the same
    // cycle never frees a slot for a push.
    assign w_free   = CW'(DEPTH) - r_count;

    assign w_acc_a  = a_valid & w_a_ready;
    assign w_acc_b  = b_valid & w_b_ready;
    assign w_pop    = rdy & (r_count != '0);
    assign w_n_push = {1'b0, w_acc_a} + {1'b0, w_acc_b};
    assign w_n_mis  = {1'b0, w_acc_a & a_mis} + {1'b0, w_acc_b & b_mis};

    // B lands right after A when both are taken, otherwise at the write pointer.
    assign w_wr_b   = r_wr_ptr + PW'(w_acc_a);

    // Ready generation and priority update; prio moves only on a contested single slot.
    always_comb begin
        w_a_ready  = 1'b0;
        w_b_ready  = 1'b0;
        w_prio_nxt = r_prio;
        if (!rst && rdy) begin
            if (w_free >= CW'(2)) begin
                w_a_ready = 1'b1;
                w_b_ready = 1'b1;
            end else if (w_free == CW'(1)) begin
                if (a_valid && b_valid) begin
                    if (r_prio == PRIO_A) begin
                        w_a_ready  = 1'b1;
                        w_prio_nxt = PRIO_B;
                    end else begin
                        w_b_ready  = 1'b1;
                        w_prio_nxt = PRIO_A;
                    end
                end else if (b_valid) begin
                    w_b_ready = 1'b1;
                end else begin
                    w_a_ready = 1'b1;
                end
            end
        end
    end

    // Priority state register; returns to A on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= PRIO_A;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    // FIFO storage writes; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_acc_a) begin
                r_mem_pc[r_wr_ptr] <= a_pc;
                r_mem_tk[r_wr_ptr] <= a_tk;
            end
            if (w_acc_b) begin
                r_mem_pc[w_wr_b] <= b_pc;
                r_mem_tk[w_wr_b] <= b_tk;
            end
        end
    end

    // Pointers, occupancy, feedback register and statistics; all frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_fb_ena  <= 1'b0;
            r_fb_pc   <= '0;
            r_fb_tk   <= 1'b0;
            r_cnt_br  <= '0;
            r_cnt_mis <= '0;
        end else if (rdy) begin
            r_wr_ptr  <= r_wr_ptr + PW'(w_n_push);
            r_rd_ptr  <= r_rd_ptr + PW'(w_pop);
            r_count   <= r_count + CW'(w_n_push) - CW'(w_pop);
            r_cnt_br  <= r_cnt_br + 32'(w_n_push);
            r_cnt_mis <= r_cnt_mis + 32'(w_n_mis);
            if (w_pop) begin
                r_fb_ena <= 1'b1;
                r_fb_pc  <= r_mem_pc[r_rd_ptr];
                r_fb_tk  <= r_mem_tk[r_rd_ptr];
            end else begin
                r_fb_ena <= 1'b0;
            end
        end
    end

    assign a_ready = w_a_ready;
    assign b_ready = w_b_ready;
    assign fb_ena  = r_fb_ena;
    assign fb_pc   = r_fb_pc;
    assign fb_tk   = r_fb_tk;
    assign cnt_br  = r_cnt_br;
    assign cnt_mis = r_cnt_mis;
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);

endmodule

// File: tb/tb_bp_feedback_sched.sv
// tb_bp_feedback_sched: directed scenarios with a scoreboard of expected
// feedback entries; a monitor pops and compares on every ready edge where
// the DUT raises fb_ena.
module tb_bp_feedback_sched;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        a_valid, b_valid;
    logic [31:0] a_pc, b_pc;
    logic        a_tk, a_mis, b_tk, b_mis;
    logic        a_ready, b_ready;
    logic        fb_ena, fb_tk;
    logic [31:0] fb_pc, cnt_br, cnt_mis;
    logic        full, empty;

    logic        u2_a_valid, u2_b_valid;
    logic [31:0] u2_a_pc, u2_b_pc;
    logic        u2_a_ready, u2_b_ready;
    logic        u2_fb_ena, u2_fb_tk;
    logic [31:0] u2_fb_pc, u2_cnt_br, u2_cnt_mis;
    logic        u2_full, u2_empty;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
    } ent_t;

    ent_t q[$];
    ent_t m_ent;
    logic m_rdy, m_rst;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bp_feedback_sched dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .a_valid(a_valid), .a_pc(a_pc), .a_tk(a_tk), .a_mis(a_mis),
        .b_valid(b_valid), .b_pc(b_pc), .b_tk(b_tk), .b_mis(b_mis),
        .a_ready(a_ready), .b_ready(b_ready),
        .fb_ena(fb_ena), .fb_pc(fb_pc), .fb_tk(fb_tk),
        .cnt_br(cnt_br), .cnt_mis(cnt_mis), .full(full), .empty(empty)
    );

    bp_feedback_sched #(.DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .rdy(rdy),
        .a_valid(u2_a_valid), .a_pc(u2_a_pc), .a_tk(1'b1), .a_mis(1'b0),
        .b_valid(u2_b_valid), .b_pc(u2_b_pc), .b_tk(1'b0), .b_mis(1'b1),
        .a_ready(u2_a_ready), .b_ready(u2_b_ready),
        .fb_ena(u2_fb_ena), .fb_pc(u2_fb_pc), .fb_tk(u2_fb_tk),
        .cnt_br(u2_cnt_br), .cnt_mis(u2_cnt_mis), .full(u2_full), .empty(u2_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every non-reset edge with rdy high that yields fb_ena must match the queue head.
    always @(posedge clk) begin
        m_rdy = rdy;
        m_rst = rst;
        #1;
        if (m_rst) begin
            chk1("mon.rst_fb_ena", fb_ena, 1'b0);
        end else if (m_rdy && fb_ena) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon.unexpected: got fb_pc %h with no entry expected", fb_pc);
            end else begin
                m_ent = q.pop_front();
                chk32("mon.fb_pc", fb_pc, m_ent.pc);
                chk1("mon.fb_tk", fb_tk, m_ent.tk);
            end
        end
    end

    // Drive one cycle at a negedge, check readies against hand-computed values,
    // queue the entries expected to be accepted, then advance to the next negedge.
    task automatic drv(input logic r,
                       input logic av, input logic [31:0] apc, input logic atk, input logic amis,
                       input logic bv, input logic [31:0] bpc, input logic btk, input logic bmis,
                       input logic ear, input logic ebr, input string tag);
        ent_t e;
        rdy = r;
        a_valid = av; a_pc = apc; a_tk = atk; a_mis = amis;
        b_valid = bv; b_pc = bpc; b_tk = btk; b_mis = bmis;
        #1;
        chk1({tag, ".a_ready"}, a_ready, ear);
        chk1({tag, ".b_ready"}, b_ready, ebr);
        if (av && ear) begin
            e.pc = apc; e.tk = atk;
            q.push_back(e);
        end
        if (bv && ebr) begin
            e.pc = bpc; e.tk = btk;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ear, input logic ebr, input string tag);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, ear, ebr, tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        rdy = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        a_pc = 32'hDEAD_0000; b_pc = 32'hDEAD_0004;
        a_tk = 1'b1; b_tk = 1'b1; a_mis = 1'b1; b_mis = 1'b1;
        u2_a_valid = 1'b0; u2_b_valid = 1'b0;
        u2_a_pc = '0; u2_b_pc = '0;
        q.delete();
        #1;
        chk1({tag, ".rst_a_ready"}, a_ready, 1'b0);
        chk1({tag, ".rst_b_ready"}, b_ready, 1'b0);
        @(negedge clk);
        chk1({tag, ".rst_empty"}, empty, 1'b1);
        chk1({tag, ".rst_full"}, full, 1'b0);
        chk1({tag, ".rst_fb_ena"}, fb_ena, 1'b0);
        chk32({tag, ".rst_cnt_br"}, cnt_br, 32'h0);
        chk32({tag, ".rst_cnt_mis"}, cnt_mis, 32'h0);
        rst = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    // Idle until every expected entry has been emitted, with a cycle bound.
    task automatic drain(input string tag);
        for (int i = 0; i < 8 && q.size() > 0; i++) idle(1'b1, 1'b1, {tag, ".drain"});
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL %s.drain: got %0d entries left expected 0", tag, q.size());
        end
        idle(1'b1, 1'b1, {tag, ".post"});
        chk1({tag, ".post_fb_ena"}, fb_ena, 1'b0);
        chk1({tag, ".post_empty"}, empty, 1'b1);
    endtask

    initial begin
        do_reset("t1");
        // Single push: one cycle of residence, then one feedback pulse.
        drv(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, "t1.push");
        chk1("t1.e0_fb_ena", fb_ena, 1'b0);
        chk32("t1.e0_cnt_br", cnt_br, 32'd1);
        chk1("t1.e0_empty", empty, 1'b0);
        idle(1'b1, 1'b1, "t1.i1");
        chk1("t1.e1_fb_ena", fb_ena, 1'b1);
        chk32("t1.e1_fb_pc", fb_pc, 32'h100);
        chk1("t1.e1_fb_tk", fb_tk, 1'b1);
        idle(1'b1, 1'b1, "t1.i2");
        chk1("t1.e2_fb_ena", fb_ena, 1'b0);
        chk32("t1.e2_fb_pc_hold", fb_pc, 32'h100);
        chk32("t1.cnt_br", cnt_br, 32'd1);
        chk32("t1.cnt_mis", cnt_mis, 32'd0);
        chk1("t1.empty", empty, 1'b1);

        do_reset("t2");
        // Dual push into an empty FIFO; A precedes B on the feedback port.
        drv(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 32'h204, 1'b1, 1'b1, 1'b1, 1'b1, "t2.dual");
        chk32("t2.cnt_br", cnt_br, 32'd2);
        chk32("t2.cnt_mis", cnt_mis, 32'd1);
        chk1("t2.e0_fb_ena", fb_ena, 1'b0);
        idle(1'b1, 1'b1, "t2.i1");
        chk1("t2.e1_fb_ena", fb_ena, 1'b1);
        chk32("t2.e1_fb_pc", fb_pc, 32'h200);
        idle(1'b1, 1'b1, "t2.i2");
        chk1("t2.e2_fb_ena", fb_ena, 1'b1);
        chk32("t2.e2_fb_pc", fb_pc, 32'h204);
        chk1("t2.e2_fb_tk", fb_tk, 1'b1);
        idle(1'b1, 1'b1, "t2.i3");
        chk1("t2.e3_fb_ena", fb_ena, 1'b0);
        chk1("t2.e3_empty", empty, 1'b1);

        do_reset("t3");
        // Saturate to one free slot, then alternate on contested cycles.
        drv(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'h304, 1'b1, 1'b1, 1'b1, 1'b1, "t3.c1");
        drv(1'b1, 1'b1, 32'h308, 1'b0, 1'b0, 1'b1, 32'h30C, 1'b1, 1'b1, 1'b1, 1'b1, "t3.c2");
        chk1("t3.c2_full", full, 1'b0);
        chk1("t3.c2_empty", empty, 1'b0);
        drv(1'b1, 1'b1, 32'h310, 1'b0, 1'b0, 1'b1, 32'h314, 1'b1, 1'b1, 1'b1, 1'b0, "t3.c3");
        drv(1'b1, 1'b1, 32'h318, 1'b0, 1'b0, 1'b1, 32'h314, 1'b1, 1'b1, 1'b0, 1'b1, "t3.c4");
        drv(1'b1, 1'b1, 32'h318, 1'b0, 1'b0, 1'b1, 32'h31C, 1'b1, 1'b1, 1'b1, 1'b0, "t3.c5");
        chk32("t3.c5_cnt_br", cnt_br, 32'd7);
        chk32("t3.c5_cnt_mis", cnt_mis, 32'd3);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h320, 1'b0, 1'b0, 1'b0, 1'b1, "t3.c6");
        drv(1'b1, 1'b1, 32'h324, 1'b0, 1'b0, 1'b1, 32'h328, 1'b1, 1'b1, 1'b0, 1'b1, "t3.c7");
        idle(1'b1, 1'b0, "t3.c8");
        chk32("t3.cnt_br", cnt_br, 32'd9);
        chk32("t3.cnt_mis", cnt_mis, 32'd4);
        chk1("t3.full", full, 1'b0);
        drain("t3");

        do_reset("t4");
        // Stall with a feedback pulse pending: everything holds, no duplicate afterwards.
        drv(1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 32'h404, 1'b0, 1'b0, 1'b1, 1'b1, "t4.dual");
        idle(1'b1, 1'b1, "t4.i1");
        chk1("t4.e1_fb_ena", fb_ena, 1'b1);
        chk32("t4.e1_fb_pc", fb_pc, 32'h400);
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b1, 32'h408, 1'b1, 1'b1, 1'b1, 32'h40C, 1'b0, 1'b1, 1'b0, 1'b0, "t4.stall");
            chk1("t4.stall_fb_ena", fb_ena, 1'b1);
            chk32("t4.stall_fb_pc", fb_pc, 32'h400);
            chk1("t4.stall_fb_tk", fb_tk, 1'b1);
            chk32("t4.stall_cnt_br", cnt_br, 32'd2);
            chk32("t4.stall_cnt_mis", cnt_mis, 32'd0);
            chk1("t4.stall_empty", empty, 1'b0);
        end
        idle(1'b1, 1'b1, "t4.resume");
        chk1("t4.resume_fb_ena", fb_ena, 1'b1);
        chk32("t4.resume_fb_pc", fb_pc, 32'h404);
        chk1("t4.resume_fb_tk", fb_tk, 1'b0);
        drain("t4");

        do_reset("t5");
        // Reset with entries queued: nothing stale may come out later.
        drv(1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 1'b1, 32'h504, 1'b1, 1'b1, 1'b1, 1'b1, "t5.d1");
        drv(1'b1, 1'b1, 32'h508, 1'b0, 1'b1, 1'b1, 32'h50C, 1'b1, 1'b1, 1'b1, 1'b1, "t5.d2");
        chk1("t5.pre_empty", empty, 1'b0);
        chk32("t5.pre_cnt_mis", cnt_mis, 32'd4);
        do_reset("t5.mid");
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b1, "t5.after");
            chk1("t5.after_fb_ena", fb_ena, 1'b0);
            chk1("t5.after_empty", empty, 1'b1);
        end

        do_reset("t6");
        // Counter wrap: preset near the top, then a dual push crosses zero.
        force dut.r_cnt_br = 32'hFFFF_FFFF;
        #1;
        release dut.r_cnt_br;
        drv(1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 1'b1, 32'h704, 1'b1, 1'b0, 1'b1, 1'b1, "t6.dual");
        chk32("t6.cnt_br_wrap", cnt_br, 32'h0000_0001);
        chk32("t6.cnt_mis", cnt_mis, 32'd0);
        drain("t6");

        do_reset("t7");
        // Two-entry instance: a dual push from empty fills it completely.
        u2_a_valid = 1'b1; u2_a_pc = 32'h600;
        u2_b_valid = 1'b1; u2_b_pc = 32'h604;
        #1;
        chk1("t7.c1_a_ready", u2_a_ready, 1'b1);
        chk1("t7.c1_b_ready", u2_b_ready, 1'b1);
        @(negedge clk);
        chk1("t7.full", u2_full, 1'b1);
        chk1("t7.empty", u2_empty, 1'b0);
        u2_a_pc = 32'h608; u2_b_pc = 32'h60C;
        #1;
        chk1("t7.full_a_ready", u2_a_ready, 1'b0);
        chk1("t7.full_b_ready", u2_b_ready, 1'b0);
        @(negedge clk);
        chk1("t7.e2_full", u2_full, 1'b0);
        chk1("t7.e2_fb_ena", u2_fb_ena, 1'b1);
        chk32("t7.e2_fb_pc", u2_fb_pc, 32'h600);
        u2_a_valid = 1'b0; u2_b_valid = 1'b0;
        #1;
        chk1("t7.idle_a_ready", u2_a_ready, 1'b1);
        chk1("t7.idle_b_ready", u2_b_ready, 1'b0);
        @(negedge clk);
        chk32("t7.e3_fb_pc", u2_fb_pc, 32'h604);
        chk1("t7.e3_fb_tk", u2_fb_tk, 1'b0);
        chk32("t7.cnt_br", u2_cnt_br, 32'd2);
        chk32("t7.cnt_mis", u2_cnt_mis, 32'd1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_feedback_sched.md
BP_FEEDBACK_SCHED -- requirements
Module: bp_feedback_sched

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, >= 2.
REQ-002 Port clk  input  1  clock; all state SHALL change on its rising edge only.
REQ-003 Port rst  input  1  reset, synchronous, active-high; clock clk.
REQ-004 Port rdy  input  1  global ready; low SHALL freeze all state.
REQ-005 Ports a_valid/b_valid  input  1  requester A/B carries a resolved branch.
REQ-006 Ports a_pc/b_pc  input  32  branch instruction address.
REQ-007 Ports a_tk/b_tk  input  1  actual outcome (1 = taken).
REQ-008 Ports a_mis/b_mis  input  1  branch was mispredicted.
REQ-009 Ports a_ready/b_ready  output  1  push accepted this cycle when high together with the matching valid.
REQ-010 Port fb_ena  output  1  BHT update strobe to predictor, registered.
REQ-011 Port fb_pc  output  32  update address, registered.
REQ-012 Port fb_tk  output  1  update direction, registered.
REQ-013 Ports cnt_br/cnt_mis  output  32  accepted-branch / accepted-mispredict counters.
REQ-014 Ports full/empty  output  1  FIFO occupancy flags (count==DEPTH / count==0).

Function
REQ-015 SHALL hold a circular FIFO of {pc, tk}; read/write pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-016 free = DEPTH - count at cycle start; pops in the same cycle SHALL NOT add space (no bypass).
REQ-017 rdy=0: a_ready=b_ready=0, no push, no pop, fb_*, counters, priority bit SHALL hold.
REQ-018 rdy=1, free>=2: a_ready=b_ready=1.
REQ-019 rdy=1, free==1, one valid: that requester ready=1, other 0.
REQ-020 rdy=1, free==1, both valid (contested): only requester owning priority bit prio ready=1; prio SHALL flip to the loser at that edge.
REQ-021 rdy=1, free==1, neither valid: a_ready=1, b_ready=0.
REQ-022 rdy=1, free==0: a_ready=b_ready=0.
REQ-023 prio SHALL change only on contested grants; a_ready/b_ready SHALL depend only on state, rdy and the other port's valid.
REQ-024 Both accepted same edge: A SHALL be written at wr_ptr, B at wr_ptr+1; wr_ptr advances by 2.
REQ-025 Pop: each edge with rdy=1 and count>0 (pre-push), head SHALL be popped and loaded into fb_pc/fb_tk with fb_ena=1.
REQ-026 Edge with rdy=1 and count==0: fb_ena SHALL load 0; fb_pc/fb_tk hold.
REQ-027 Minimum latency: entry pushed at edge E0 SHALL appear on fb_* after edge E1 (one-cycle residence); exactly one pop per rdy edge.
REQ-028 Entries SHALL reach fb_* in acceptance order; each exactly once, even across rdy=0 stalls (held fb_ena consumed on first rdy edge).
REQ-029 Same-edge push and pop SHALL update count by (pushes - pop).
REQ-030 cnt_br SHALL add the number of accepted pushes (0..2); cnt_mis SHALL add accepted pushes with mis=1; both wrap modulo 2^32.
REQ-031 mis of a rejected request SHALL NOT be counted.

Reset
REQ-032 On rst edge (priority over rdy): pointers, count, cnt_br, cnt_mis, fb_ena, fb_pc, fb_tk SHALL become 0; prio SHALL become A; contents discarded.
REQ-033 rst mid-operation SHALL drop all queued entries; no fb_ena pulse SHALL follow from them.
REQ-034 During rst cycle a_ready=b_ready SHALL be 0.

Verification
REQ-035 Reset, then single A push pc=0x100 tk=1 mis=0 -> fb_ena=1, fb_pc=0x100, fb_tk=1 one cycle after push edge; next cycle fb_ena=0; cnt_br=1, cnt_mis=0.
REQ-036 A pc=0x200 and B pc=0x204 (mis=1) same cycle, empty FIFO -> both accepted; fb_pc 0x200 then 0x204 on consecutive cycles; cnt_br=2, cnt_mis=1.
REQ-037 DEPTH=4, hold both valid every cycle with rdy=1 until count=3, then contested -> A granted, then next contested -> B granted (alternation); full asserts only when count=4.
REQ-038 fb_ena=1 loaded, then rdy=0 for 3 cycles -> fb_*, count, counters unchanged, readies 0; on rdy return, next entry loaded, no duplicate.
REQ-039 Fill FIFO, assert rst one cycle -> empty=1, fb_ena=0, counters 0; no stale entry emitted afterwards.
REQ-040 Preload cnt_br to 0xFFFFFFFF via pushes (force), then dual push -> cnt_br=0x00000001.
